// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl: round sequencer and two-player arbiter for the reaction game
//
// Arms on start, counts COUNTDOWN_TICKS tick pulses, lights GO, and awards
// the point to the first press. Rounds repeat until a player reaches
// WIN_SCORE. All outputs are registered.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   i_start        1-cycle pulse, arms a game from IDLE or OVER
//   i_tick         1-cycle pulse from the slow-time divider
//   i_p1_btn       1-cycle press pulse, player 1
//   i_p2_btn       1-cycle press pulse, player 2
//   o_active       game in progress (COUNTDOWN or GO)
//   o_go_led       high while in GO
//   o_p1_score     player 1 points
//   o_p2_score     player 2 points
//   o_winner       00 none, 01 P1, 10 P2; valid in OVER
//   o_round_done   1-cycle pulse when a round ends (point or timeout)
//
// Optional feature macro: FALSE_START_PENALTY_EN
//   defined   - a press during COUNTDOWN gives the opponent a point
//               (no point if both press together), ends the round and
//               reloads the countdown
//   undefined - presses during COUNTDOWN are ignored
module reaction_round_ctrl #(
    parameter int WIN_SCORE       = 7,
    parameter int SCORE_W         = 3,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int TIMEOUT_TICKS   = 15,
    parameter int CNT_W           = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_tick,
    input  logic               i_p1_btn,
    input  logic               i_p2_btn,
    output logic               o_active,
    output logic               o_go_led,
    output logic [SCORE_W-1:0] o_p1_score,
    output logic [SCORE_W-1:0] o_p2_score,
    output logic [1:0]         o_winner,
    output logic               o_round_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CD   = 2'd1;
    localparam logic [1:0] S_GO   = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;
    localparam logic [CNT_W-1:0]   CD_LOAD = CNT_W'(COUNTDOWN_TICKS);
    localparam logic [CNT_W-1:0]   TO_LOAD = CNT_W'(TIMEOUT_TICKS);
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
`ifdef FALSE_START_PENALTY_EN
    localparam logic FS_EN = 1'b1;
`else
    localparam logic FS_EN = 1'b0;
`endif
    logic [1:0]         r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [SCORE_W-1:0] r_p1, r_p2, w_p1_n, w_p2_n;
    logic [1:0]         r_winner, w_winner_n;
    logic               r_done, w_done_n;
    // 0: P1 holds tie priority, 1: P2 holds it
    logic               r_prio, w_prio_n;
    logic               r_active, r_go;
    logic               w_go, w_fs, w_p1_pt, w_p2_pt, w_press;

    assign w_go    = (r_state == S_GO);
    assign w_fs    = FS_EN && (r_state == S_CD);
    // In GO the press earns the point; a false start gives it to the opponent
    assign w_p1_pt = w_go ? (i_p1_btn & (~i_p2_btn | ~r_prio)) : (w_fs & i_p2_btn & ~i_p1_btn);
    assign w_p2_pt = w_go ? (i_p2_btn & (~i_p1_btn | r_prio))  : (w_fs & i_p1_btn & ~i_p2_btn);
    assign w_press = (w_go | w_fs) & (i_p1_btn | i_p2_btn);

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_p1_n     = r_p1;
        w_p2_n     = r_p2;
        w_winner_n = r_winner;
        w_done_n   = 1'b0;
        w_prio_n   = r_prio;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (i_start) begin
                    w_state_n  = S_CD;
                    w_cnt_n    = CD_LOAD;
                    w_p1_n     = '0;
                    w_p2_n     = '0;
                    w_winner_n = 2'b00;
                end
            end
            S_CD, S_GO: begin
                if (w_press) begin
                    w_p1_n    = r_p1 + SCORE_W'(w_p1_pt);
                    w_p2_n    = r_p2 + SCORE_W'(w_p2_pt);
                    w_done_n  = 1'b1;
                    w_state_n = S_CD;
                    w_cnt_n   = CD_LOAD;
                    if (w_go && i_p1_btn && i_p2_btn)
                        w_prio_n = ~r_prio;
                    if (w_p1_n == WIN) begin
                        w_state_n  = S_OVER;
                        w_winner_n = 2'b01;
                    end else if (w_p2_n == WIN) begin
                        w_state_n  = S_OVER;
                        w_winner_n = 2'b10;
                    end
                end else if (i_tick) begin
                    if (r_cnt != CNT_W'(1)) begin
                        w_cnt_n = r_cnt - CNT_W'(1);
                    end else if (w_go) begin
                        w_state_n = S_CD;
                        w_cnt_n   = CD_LOAD;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n = S_GO;
                        w_cnt_n   = TO_LOAD;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_winner <= 2'b00;
            r_done   <= 1'b0;
            r_prio   <= 1'b0;
            r_active <= 1'b0;
            r_go     <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_p1     <= w_p1_n;
            r_p2     <= w_p2_n;
            r_winner <= w_winner_n;
            r_done   <= w_done_n;
            r_prio   <= w_prio_n;
            r_active <= (w_state_n == S_CD) || (w_state_n == S_GO);
            r_go     <= (w_state_n == S_GO);
        end
    end

    assign o_active     = r_active;
    assign o_go_led     = r_go;
    assign o_p1_score   = r_p1;
    assign o_p2_score   = r_p2;
    assign o_winner     = r_winner;
    assign o_round_done = r_done;
endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb_reaction_round_ctrl: directed scoreboard bench for reaction_round_ctrl
module tb_reaction_round_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0, start = 1'b0, tick = 1'b0, p1_btn = 1'b0, p2_btn = 1'b0;
    logic       active, go_led, round_done;
    logic [2:0] p1_score, p2_score;
    logic [1:0] winner;
    logic [10:0] q[$];
    int errors = 0;
    int checks = 0;

    reaction_round_ctrl #(
        .WIN_SCORE(2), .SCORE_W(3), .COUNTDOWN_TICKS(3), .TIMEOUT_TICKS(4), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .i_start(start), .i_tick(tick),
        .i_p1_btn(p1_btn), .i_p2_btn(p2_btn),
        .o_active(active), .o_go_led(go_led), .o_p1_score(p1_score),
        .o_p2_score(p2_score), .o_winner(winner), .o_round_done(round_done)
    );

    always #5 clk = ~clk;

    // packs {active, go_led, p1_score, p2_score, winner, round_done}
    function automatic logic [10:0] e(input logic a, input logic g, input int s1, input int s2,
                                      input logic [1:0] w, input logic d);
        return {a, g, 3'(s1), 3'(s2), w, d};
    endfunction

    task automatic step(input string tag, input logic rs, input logic st, input logic tk,
                        input logic b1, input logic b2, input logic [10:0] exp);
        logic [10:0] obs, ex;
        reset = rs; start = st; tick = tk; p1_btn = b1; p2_btn = b2;
        q.push_back(exp);
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0; tick = 1'b0; p1_btn = 1'b0; p2_btn = 1'b0;
        obs = {active, go_led, p1_score, p2_score, winner, round_done};
        ex = q.pop_front();
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
        end
    endtask

    task automatic to_go(input int s1, input int s2);
        step("cd_tick1", 0, 0, 1, 0, 0, e(1, 0, s1, s2, 2'b00, 0));
        step("cd_tick2", 0, 0, 1, 0, 0, e(1, 0, s1, s2, 2'b00, 0));
        step("go_on",    0, 0, 1, 0, 0, e(1, 1, s1, s2, 2'b00, 0));
    endtask

    initial begin
        int fs;
`ifdef FALSE_START_PENALTY_EN
        fs = 1;
`else
        fs = 0;
`endif
        step("reset",       1, 0, 0, 0, 0, e(0, 0, 0, 0, 2'b00, 0));
        step("idle_ignore", 0, 0, 1, 1, 1, e(0, 0, 0, 0, 2'b00, 0));
        step("start",       0, 1, 0, 0, 0, e(1, 0, 0, 0, 2'b00, 0));
        step("cd_hold",     0, 0, 0, 0, 0, e(1, 0, 0, 0, 2'b00, 0));
        to_go(0, 0);
        step("go_hold",     0, 0, 0, 0, 0, e(1, 1, 0, 0, 2'b00, 0));
        step("p2_point",    0, 0, 0, 0, 1, e(1, 0, 0, 1, 2'b00, 1));
        step("done_pulse",  0, 0, 0, 0, 0, e(1, 0, 0, 1, 2'b00, 0));
        to_go(0, 1);
        step("to_tick1",    0, 0, 1, 0, 0, e(1, 1, 0, 1, 2'b00, 0));
        step("to_tick2",    0, 0, 1, 0, 0, e(1, 1, 0, 1, 2'b00, 0));
        step("to_tick3",    0, 0, 1, 0, 0, e(1, 1, 0, 1, 2'b00, 0));
        step("timeout",     0, 0, 1, 0, 0, e(1, 0, 0, 1, 2'b00, 1));
        to_go(0, 1);
        step("go_tick1",    0, 0, 1, 0, 0, e(1, 1, 0, 1, 2'b00, 0));
        step("go_tick2",    0, 0, 1, 0, 0, e(1, 1, 0, 1, 2'b00, 0));
        step("go_tick3",    0, 0, 1, 0, 0, e(1, 1, 0, 1, 2'b00, 0));
        step("press_beats_tick", 0, 0, 1, 1, 0, e(1, 0, 1, 1, 2'b00, 1));
        to_go(1, 1);
        step("p1_wins",     0, 0, 0, 1, 0, e(0, 0, 2, 1, 2'b01, 1));
        step("over_ignore", 0, 0, 1, 1, 1, e(0, 0, 2, 1, 2'b01, 0));
        step("restart",     0, 1, 0, 0, 0, e(1, 0, 0, 0, 2'b00, 0));
        to_go(0, 0);
        step("tie_p1",      0, 0, 0, 1, 1, e(1, 0, 1, 0, 2'b00, 1));
        to_go(1, 0);
        step("tie_p2",      0, 0, 0, 1, 1, e(1, 0, 1, 1, 2'b00, 1));
        to_go(1, 1);
        step("tie_p1_again", 0, 0, 0, 1, 1, e(0, 0, 2, 1, 2'b01, 1));
        step("restart2",    0, 1, 0, 0, 0, e(1, 0, 0, 0, 2'b00, 0));
        step("cd_p1_press", 0, 0, 0, 1, 0, e(1, 0, 0, fs, 2'b00, fs[0]));
        to_go(0, fs);
        step("reset_in_go", 1, 0, 0, 1, 0, e(0, 0, 0, 0, 2'b00, 0));
        step("post_reset",  0, 0, 1, 0, 0, e(0, 0, 0, 0, 2'b00, 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
